// File: rtl/fmul_pkg.sv
// Shared definitions for the FloPoCo fmul format (2 exception bits, sign, WE exponent, WF fraction).
package fmul_pkg;

    localparam int WE       = 4;
    localparam int WF       = 4;
    localparam int W        = WE + WF + 3;
    localparam int FMUL_LAT = 2;

    typedef enum logic [1:0] {
        EXC_ZERO   = 2'b00,
        EXC_NORMAL = 2'b01,
        EXC_INF    = 2'b10,
        EXC_NAN    = 2'b11
    } exc_t;

    // Exponent bias is 7: 2.0 = 1.0*2^1, 3.0 = 1.5*2^1, 6.0 = 1.5*2^2.
    localparam logic [W-1:0] F_2_0 = 11'b01_0_1000_0000;
    localparam logic [W-1:0] F_3_0 = 11'b01_0_1000_1000;
    localparam logic [W-1:0] F_6_0 = 11'b01_0_1001_1000;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick across N_REQ requesters; the pointer moves past the winner on every grant.
module rr_arbiter #(
    parameter int  N_REQ = 4,
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   winner,
    output logic             fire
);

    logic [IDW-1:0] ptr;
    logic           found;

    // Scan ptr, ptr+1, ... modulo N_REQ; the first requester seen wins.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found && en) begin
            grant[winner] = 1'b1;
        end
    end

    assign fire = found & en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (fire) begin
            if (int'(winner) == N_REQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= winner + IDW'(1);
            end
        end
    end

endmodule

// File: rtl/fmul_share_arbiter.sv
// Shares one pipelined fmul among N_REQ requesters and routes each product back by tag.
// Optional per-requester grant counters when FMUL_SHARE_ARBITER_STATS_EN is defined.
module fmul_share_arbiter
    import fmul_pkg::*;
#(
    parameter int  N_REQ = 4,
    parameter int  WE    = fmul_pkg::WE,
    parameter int  WF    = fmul_pkg::WF,
    parameter int  LAT   = FMUL_LAT,
    localparam int W     = WE + WF + 3,
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_x,
    input  logic [N_REQ*W-1:0] req_y,
    output logic [N_REQ-1:0]   req_ready,
    output logic [W-1:0]       fmul_x,
    output logic [W-1:0]       fmul_y,
    input  logic [W-1:0]       fmul_r,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [W-1:0]       resp_data,
    output logic               busy
`ifdef FMUL_SHARE_ARBITER_STATS_EN
    ,
    output logic [N_REQ*16-1:0] grant_count
`endif
);

    logic [IDW-1:0] winner;
    logic           fire;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .clk    (clk),
        .rst_n  (reset),
        .en     (en),
        .req    (req_valid),
        .grant  (req_ready),
        .winner (winner),
        .fire   (fire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fmul_x <= '0;
            fmul_y <= '0;
        end else if (fire) begin
            fmul_x <= req_x[int'(winner)*W +: W];
            fmul_y <= req_y[int'(winner)*W +: W];
        end
    end

    // Stage k holds the op issued k+1 edges ago; stage LAT lines up with a valid fmul_r.
    logic [LAT:0]   tag_v;
    logic [IDW-1:0] tag_id [LAT+1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_v     <= {tag_v[LAT-1:0], fire};
            tag_id[0] <= winner;
            for (int k = 1; k <= LAT; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else if (tag_v[LAT]) begin
            resp_valid <= N_REQ'(1) << tag_id[LAT];
            resp_data  <= fmul_r;
        end else begin
            resp_valid <= '0;
        end
    end

    assign busy = |tag_v;

`ifdef FMUL_SHARE_ARBITER_STATS_EN
    logic [15:0] grant_cnt [N_REQ];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i]) begin
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_count[i*16 +: 16] = grant_cnt[i];
        end
    end
`endif

endmodule
